frame_buffer_source: RTL
========================

// Module: frame_buffer_source
// PURPOSE
//  Double-buffered pixel store feeding the VGA video driver's x/y/r/g/b pixel interface.
//  A drawing engine writes 3-bit colour pixels into the back buffer via a valid/ready port.
//  The video driver's x,y request reads the front buffer and is answered with 8-bit r,g,b.
//  Includes a hardware clear engine and a frame-synchronous buffer swap.
// PARAMETERS
//  WIDTH   160  pixels per line; must equal the driver's WIDTH
//  HEIGHT  120  lines per frame; must equal the driver's HEIGHT
//  DEPTH   WIDTH*HEIGHT (derived localparam)  words per buffer; 2*DEPTH x 3-bit total storage
// PORTS
//  CLOCK_50     in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  x            in   10  display column from video driver
//  y            in   9   display row from video driver
//  r,g,b        out  8   pixel colour to video driver (each 8 bits)
//  wr_valid     in   1   drawing engine presents a pixel write
//  wr_ready     out  1   block can accept a write this cycle
//  wr_x         in   10  write column
//  wr_y         in   9   write row
//  wr_color     in   3   {R,G,B} one bit per channel
//  clear_req    in   1   pulse: fill back buffer with clear_color
//  clear_color  in   3   colour used by clear (sampled on clear_req)
//  busy         out  1   clear in progress
//  swap_req     in   1   pulse: request front/back exchange
//  frame_sync   in   1   pulse once per frame at start of vertical blank
//  disp_buf     out  1   index of buffer currently displayed (front)
// BEHAVIOUR
//  Reset: r=g=b=0, busy=0, wr_ready=0, disp_buf=0, swap pending=0, FSM=IDLE.
//   RAM contents are not cleared. wr_ready rises the first cycle after reset deasserts.
//  Read path: rd_addr = y*WIDTH + x (combinational), synchronous RAM read of the front buffer.
//   r,g,b are valid exactly 1 CLOCK_50 cycle after x,y change. This fits inside one 25 MHz pixel period.
//   x>=WIDTH or y>=HEIGHT: r,g,b = 0 one cycle later; no out-of-range RAM access.
//   Palette: each channel = colour bit ? 8'hFF : 8'h00.
//  Write path: a transfer occurs when wr_valid & wr_ready on a CLOCK_50 edge.
//   Writes go to the back buffer (~disp_buf), address wr_y*WIDTH + wr_x.
//   An out-of-range wr_x/wr_y is accepted (handshake completes) and dropped.
//   wr_ready = (state==IDLE) & ~reset. It does not depend on wr_valid.
//  FSM states: IDLE, CLEAR.
//   IDLE -> CLEAR on clear_req: latch clear_color, caddr=0, busy=1, wr_ready=0 the next cycle.
//    If clear_req and wr_valid fall in the same cycle, the write completes first, then the clear starts.
//   CLEAR: write the latched colour to back[caddr], one word per cycle, caddr++.
//   After the write at caddr==DEPTH-1 -> IDLE. busy=0 the next cycle.
//    Total busy time = DEPTH cycles.
//   clear_req while in CLEAR: ignored; the clear is not restarted.
//  Swap: swap_req sets pending.
//   On a frame_sync cycle with pending (or swap_req in the same cycle) and state==IDLE:
//    disp_buf toggles and pending clears.
//   During CLEAR the swap stays pending and takes effect on the first frame_sync after busy falls.
//   Repeated swap_req before frame_sync produce one swap only.
//  Reset mid-clear or with a swap pending: both are abandoned; returns to the reset state.
//  Read and write ports never address the same buffer.
// TESTING
//  1 Reset then present x=0,y=0 -> r,g,b=0 during reset; wr_ready=1 the first cycle after release.
//  2 Write (5,3,3'b101); swap_req; pulse frame_sync; drive x=5,y=3.
//    -> disp_buf=1; one cycle later r=FF,g=00,b=FF.
//    Neighbour (6,3) shows the pre-clear value of the buffer.
//  3 clear_req with clear_color=3'b010 -> busy high for exactly 19200 cycles and wr_ready low throughout.
//    After swap, every sampled pixel reads g=FF, r=b=00.
//  4 Drive x=160,y=0 and x=0,y=120 -> r,g,b=0.
//    Write to (200,10) -> handshake completes; no pixel changes.
//  5 swap_req during CLEAR plus a frame_sync mid-clear -> disp_buf unchanged.
//    The next frame_sync after busy falls toggles disp_buf exactly once.
//  6 Assert reset at caddr≈9000 -> busy=0, disp_buf=0 next cycle; a later clear_req runs a full DEPTH-cycle clear.

Source files
------------

// File: rtl/frame_buffer_source.sv
// Double-buffered 3-bit pixel store for the VGA driver.
// Back buffer takes draws and clears; front buffer feeds r,g,b.
module frame_buffer_source #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  output logic       busy,
  input  logic       swap_req,
  input  logic       frame_sync,
  output logic       disp_buf
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(2 * DEPTH);
  localparam logic [9:0] XLIM = 10'(WIDTH);
  localparam logic [8:0] YLIM = 9'(HEIGHT);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, state_d;
  logic [AW-1:0] caddr, caddr_d;
  logic [2:0] ccolor, ccolor_d;
  logic pending;
  logic swap_now;

  logic [2:0] mem [0:2*DEPTH-1];
  logic [2:0] rd_data;
  logic rd_ok;
  logic rd_in, wr_in, wr_fire;
  logic [AW-1:0] rd_addr, wr_addr;

  // Buffer 1 lives in the upper half of the shared array.
  function automatic logic [PW-1:0] phys(
    input logic sel,
    input logic [AW-1:0] a
  );
    return sel ? PW'(a) + PW'(DEPTH) : PW'(a);
  endfunction

  assign rd_in = (x < XLIM) && (y < YLIM);
  assign rd_addr = rd_in ?
    AW'(y) * AW'(WIDTH) + AW'(x) : '0;

  assign wr_in = (wr_x < XLIM) && (wr_y < YLIM);
  assign wr_addr = wr_in ?
    AW'(wr_y) * AW'(WIDTH) + AW'(wr_x) : '0;

  assign wr_ready = (state == IDLE) && !reset;
  assign wr_fire = wr_valid && wr_ready;
  assign busy = (state == CLEAR);

  always_comb begin
    state_d = state;
    caddr_d = caddr;
    ccolor_d = ccolor;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          caddr_d = '0;
          ccolor_d = clear_color;
        end
      end
      CLEAR: begin
        if (caddr == LAST) state_d = IDLE;
        else caddr_d = caddr + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      caddr <= '0;
      ccolor <= '0;
    end else begin
      state <= state_d;
      caddr <= caddr_d;
      ccolor <= ccolor_d;
    end
  end

  // A swap is held off while a clear still owns the back buffer.
  assign swap_now = frame_sync && (pending || swap_req)
                    && (state == IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      disp_buf <= 1'b0;
      pending <= 1'b0;
    end else if (swap_now) begin
      disp_buf <= ~disp_buf;
      pending <= 1'b0;
    end else if (swap_req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[phys(~disp_buf, caddr)] <= ccolor;
      else if (wr_fire && wr_in)
        mem[phys(~disp_buf, wr_addr)] <= wr_color;
    end
    rd_data <= mem[phys(disp_buf, rd_addr)];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) rd_ok <= 1'b0;
    else rd_ok <= rd_in;
  end

  assign r = rd_ok ? {8{rd_data[2]}} : 8'h00;
  assign g = rd_ok ? {8{rd_data[1]}} : 8'h00;
  assign b = rd_ok ? {8{rd_data[0]}} : 8'h00;

endmodule
